uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter: configurable data width, parity and stop bits.
//  Has an internal FIFO so producers can queue words back-to-back via valid/ready.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo.sv | 63 ++++++
 rtl/uart_tx_cfg.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_t;

    function automatic int wc_startval(input int fclk, input int baud);
        return (fclk / baud) - 1;
    endfunction

    // The reserved encoding behaves as "no parity".
    function automatic logic parity_enabled(input parity_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through read data and occupancy count.
module uart_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_LEVEL);
    assign empty    = (count == '0);
    assign level    = count;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable width, parity and stop bits, fed from an internal FIFO.
// Each queued word carries its own parity/stop settings, captured when it is pushed.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int FCLK      = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_BITS-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [1:0]             parity_mode,
    input  logic                   stop2,
    output logic                   tx,
    output logic                   tx_idle,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int BIT_CYCLES = FCLK / BAUD;
    localparam int WC_W       = $clog2(BIT_CYCLES);
    localparam int BC_W       = $clog2(DATA_BITS);
    localparam int WORD_W     = DATA_BITS + 3;

    localparam logic [WC_W-1:0] WC_STARTVAL = WC_W'(wc_startval(FCLK, BAUD));
    localparam logic [WC_W-1:0] WC_ONE      = WC_W'(1);
    localparam logic [BC_W-1:0] BC_LAST     = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] BC_ONE      = BC_W'(1);

    uart_tx_state_t state;
    uart_tx_state_t next_state;

    logic [WORD_W-1:0]    push_word;
    logic [WORD_W-1:0]    pop_word;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    logic [DATA_BITS-1:0] pop_bits;
    parity_t              pop_mode;
    logic                 pop_stop2;
    logic                 pop_par;

    logic [DATA_BITS-1:0] shift;
    logic [WC_W-1:0]      wc;
    logic [BC_W-1:0]      bc;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop2_l;
    logic                 second_stop;
    logic                 wc_zero;
    logic                 tx_next;

    assign push_word = {stop2, parity_mode, tx_data};

    uart_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .push_data (push_word),
        .pop       (fifo_pop),
        .pop_data  (pop_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign tx_ready  = !fifo_full;
    assign tx_idle   = (state == IDLE) && fifo_empty;
    assign wc_zero   = (wc == '0);

    assign pop_bits  = pop_word[DATA_BITS-1:0];
    assign pop_mode  = parity_t'(pop_word[DATA_BITS+1:DATA_BITS]);
    assign pop_stop2 = pop_word[DATA_BITS+2];
    assign pop_par   = (pop_mode == PAR_ODD) ? ~^pop_bits : ^pop_bits;

    always_ff @(posedge clk or negedge rst_n) begin : state_ff
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The STOP exit pops directly into START so queued frames leave with no idle gap.
    always_comb begin : state_comb
        next_state = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (wc_zero) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (wc_zero && (bc == BC_LAST)) begin
                    next_state = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (wc_zero) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (wc_zero && (!stop2_l || second_stop)) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin : output_comb
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift[0];
            PARITY:  tx_next = par_bit;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath_ff
        if (!rst_n) begin
            shift       <= '0;
            wc          <= '0;
            bc          <= '0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            stop2_l     <= 1'b0;
            second_stop <= 1'b0;
        end else if (fifo_pop) begin
            shift       <= pop_bits;
            wc          <= WC_STARTVAL;
            bc          <= '0;
            par_en      <= parity_enabled(pop_mode);
            par_bit     <= pop_par;
            stop2_l     <= pop_stop2;
            second_stop <= 1'b0;
        end else if (state != IDLE) begin
            if (wc_zero) begin
                wc <= WC_STARTVAL;
                if (state == DATA) begin
                    shift <= shift >> 1;
                    if (bc != BC_LAST) begin
                        bc <= bc + BC_ONE;
                    end
                end
                if (state == STOP) begin
                    second_stop <= 1'b1;
                end
            end else begin
                wc <= wc - WC_ONE;
            end
        end
    end

    // Registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin : tx_ff
        if (!rst_n) begin
            tx <= 1'b1;
        end else begin
            tx <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench: a per-cycle scoreboard of expected line levels, built from a frame model,
// is compared against tx of an 8-bit and a 7-bit instance on every clock.
module tb_uart_tx_cfg;

    localparam int FCLK       = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int BIT_CYCLES = FCLK / BAUD;

    logic       clk;
    logic       rst_n;

    logic [7:0] tx_data8;
    logic       valid8;
    logic       ready8;
    logic [1:0] parity8;
    logic       stop2_8;
    logic       tx8;
    logic       idle8;
    logic [2:0] level8;

    logic [6:0] tx_data7;
    logic       valid7;
    logic       ready7;
    logic [1:0] parity7;
    logic       stop2_7;
    logic       tx7;
    logic       idle7;
    logic [2:0] level7;

    logic q8[$];
    logic q7[$];

    int checks = 0;
    int passes = 0;

    uart_tx_cfg #(.FCLK(FCLK), .BAUD(BAUD), .DATA_BITS(8), .DEPTH(4)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data8),
        .tx_valid    (valid8),
        .tx_ready    (ready8),
        .parity_mode (parity8),
        .stop2       (stop2_8),
        .tx          (tx8),
        .tx_idle     (idle8),
        .fifo_level  (level8)
    );

    uart_tx_cfg #(.FCLK(FCLK), .BAUD(BAUD), .DATA_BITS(7), .DEPTH(4)) dut7 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data7),
        .tx_valid    (valid7),
        .tx_ready    (ready7),
        .parity_mode (parity7),
        .stop2       (stop2_7),
        .tx          (tx7),
        .tx_idle     (idle7),
        .fifo_level  (level7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Queues the per-cycle line levels of one frame; an idle line adds the two-cycle pop latency.
    task automatic enqueue_frame(input int sel, input logic [8:0] data, input logic [1:0] mode,
                                 input logic s2);
        logic bits[$];
        logic par;
        par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < sel; i++) begin
            bits.push_back(data[i]);
            par = par ^ data[i];
        end
        if (mode == 2'b01) bits.push_back(par);
        if (mode == 2'b10) bits.push_back(~par);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        if (sel == 8) begin
            if (q8.size() == 0) begin
                q8.push_back(1'b1);
                q8.push_back(1'b1);
            end
            foreach (bits[b]) repeat (BIT_CYCLES) q8.push_back(bits[b]);
        end else begin
            if (q7.size() == 0) begin
                q7.push_back(1'b1);
                q7.push_back(1'b1);
            end
            foreach (bits[b]) repeat (BIT_CYCLES) q7.push_back(bits[b]);
        end
    endtask

    task automatic tick();
        logic e8;
        logic e7;
        @(negedge clk);
        e8 = (q8.size() > 0) ? q8.pop_front() : 1'b1;
        e7 = (q7.size() > 0) ? q7.pop_front() : 1'b1;
        check_output("tx8_line", 32'(tx8), 32'(e8));
        check_output("tx7_line", 32'(tx7), 32'(e7));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int sel, input logic [8:0] data, input logic [1:0] mode,
                                  input logic s2);
        if (sel == 8) begin
            tx_data8 = data[7:0];
            parity8  = mode;
            stop2_8  = s2;
            valid8   = 1'b1;
        end else begin
            tx_data7 = data[6:0];
            parity7  = mode;
            stop2_7  = s2;
            valid7   = 1'b1;
        end
        tick();
        enqueue_frame(sel, data, mode, s2);
        valid8 = 1'b0;
        valid7 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && (q8.size() != 0 || q7.size() != 0); i++) tick();
        check_output("drain_timeout", 32'(q8.size() + q7.size()), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b1;
        tx_data8 = '0; valid8 = 1'b0; parity8 = 2'b00; stop2_8 = 1'b0;
        tx_data7 = '0; valid7 = 1'b0; parity7 = 2'b00; stop2_7 = 1'b0;
        #3 rst_n = 1'b0;
        #2;
        check_output("rst_tx",     32'(tx8),    32'd1);
        check_output("rst_idle",   32'(idle8),  32'd1);
        check_output("rst_ready",  32'(ready8), 32'd1);
        check_output("rst_level",  32'(level8), 32'd0);
        check_output("rst_tx7",    32'(tx7),    32'd1);
        check_output("rst_level7", 32'(level7), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();

        $display("[TB] 8N1 frame");
        apply_stimulus(8, 9'h055, 2'b00, 1'b0);
        check_output("idle_after_push", 32'(idle8), 32'd0);
        drain();
        check_output("idle_after_8n1", 32'(idle8), 32'd1);

        $display("[TB] parity frames");
        apply_stimulus(8, 9'h055, 2'b01, 1'b0); drain();
        apply_stimulus(8, 9'h055, 2'b10, 1'b0); drain();
        apply_stimulus(8, 9'h007, 2'b01, 1'b0); drain();
        apply_stimulus(8, 9'h007, 2'b10, 1'b0); drain();
        apply_stimulus(8, 9'h055, 2'b11, 1'b0); drain();

        $display("[TB] 7-bit, two stop bits");
        apply_stimulus(7, 9'h041, 2'b00, 1'b1);
        drain();
        check_output("idle7_after", 32'(idle7), 32'd1);

        $display("[TB] back-to-back burst");
        parity8 = 2'b00;
        stop2_8 = 1'b0;
        valid8  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tx_data8 = 8'(k);
            tick();
            if (k < 5) enqueue_frame(8, 9'(k), 2'b00, 1'b0);
        end
        check_output("burst_ready", 32'(ready8), 32'd0);
        check_output("burst_level", 32'(level8), 32'd4);
        valid8 = 1'b0;
        drain();
        check_output("burst_idle", 32'(idle8), 32'd1);

        $display("[TB] config change mid-frame");
        apply_stimulus(8, 9'h0A5, 2'b01, 1'b0);
        repeat (20) tick();
        parity8 = 2'b10;
        repeat (5) tick();
        apply_stimulus(8, 9'h03C, 2'b10, 1'b0);
        parity8 = 2'b00;
        stop2_8 = 1'b1;
        drain();

        $display("[TB] reset mid-frame");
        apply_stimulus(8, 9'h0F0, 2'b00, 1'b0);
        tick();
        apply_stimulus(8, 9'h011, 2'b00, 1'b0);
        apply_stimulus(8, 9'h022, 2'b00, 1'b0);
        check_output("queued_level", 32'(level8), 32'd2);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check_output("midrst_tx",    32'(tx8),    32'd1);
        check_output("midrst_level", 32'(level8), 32'd0);
        check_output("midrst_idle",  32'(idle8),  32'd1);
        check_output("midrst_ready", 32'(ready8), 32'd1);
        q8.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (150) tick();
        check_output("post_rst_level", 32'(level8), 32'd0);
        check_output("post_rst_idle",  32'(idle8),  32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
